// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the multiply/divide operation and FSM encodings.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } mdop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } mdstate_t;

   function automatic logic is_signed_op(input mdop_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/stage_exe_mdu_if.sv
// Execute-stage to MDU bundle: request, operands, MTHI/MTLO writes, status and HI/LO.
interface stage_exe_mdu_if #(parameter int DW = 32);
   import cpu_types_pkg::*;

   logic          start;
   mdop_t         op;
   logic [DW-1:0] opa;
   logic [DW-1:0] opb;
   logic          flush;
   logic          hi_we;
   logic          lo_we;
   logic [DW-1:0] wdat;
   logic          busy;
   logic          done;
   logic [DW-1:0] hi_out;
   logic [DW-1:0] lo_out;

   modport master (
      output start, op, opa, opb, flush, hi_we, lo_we, wdat,
      input  busy, done, hi_out, lo_out
   );

   modport slave (
      input  start, op, opa, opb, flush, hi_we, lo_we, wdat,
      output busy, done, hi_out, lo_out
   );

endinterface

// File: rtl/stage_exe_mdu_shift_core.sv
// Shared 2*DW accumulator with one shift-add (multiply) or restoring shift-subtract
// (divide, only when MDU_DIV_EN is defined) step per cycle.
module mdu_shift_core #(
   parameter int DW = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            load,
   input  logic            step_mul,
`ifdef MDU_DIV_EN
   input  logic            step_div,
`endif
   input  logic [DW-1:0]   a_in,
   input  logic [DW-1:0]   b_in,
   output logic [2*DW-1:0] acc
);

   logic [2*DW-1:0] acc_q, acc_d;
   logic [DW-1:0]   mcand_q, mcand_d;
   logic [DW:0]     sum;

   // Multiply: acc = {partial product, remaining multiplier bits}
   assign sum = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, (acc_q[0] ? mcand_q : '0)};

`ifdef MDU_DIV_EN
   // Divide: acc = {remainder, dividend/quotient}; keep the bit shifted out of the remainder
   logic [DW:0] trial;
   assign trial = acc_q[2*DW-1:DW-1] - {1'b0, mcand_q};
`endif

   always_comb begin
      acc_d   = acc_q;
      mcand_d = mcand_q;
      if (load) begin
         acc_d   = {{DW{1'b0}}, a_in};
         mcand_d = b_in;
      end else if (step_mul) begin
         acc_d = {sum, acc_q[DW-1:1]};
      end
`ifdef MDU_DIV_EN
      else if (step_div) begin
         if (!trial[DW]) acc_d = {trial[DW-1:0], acc_q[DW-2:0], 1'b1};
         else            acc_d = {acc_q[2*DW-2:0], 1'b0};
      end
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc_q   <= '0;
         mcand_q <= '0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/stage_exe_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO; divider present only when
// MDU_DIV_EN is defined, otherwise divides complete in one cycle with HI = LO = 0.
module stage_exe_mdu
   import cpu_types_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic            CLK,
   input  logic            RST,
   stage_exe_mdu_if.slave  mdu
);

   localparam int CW = $clog2(DW) + 1;

   mdstate_t        state_q, state_d;
   mdop_t           op_q, op_d;
   logic [CW-1:0]   count_q, count_d;
   logic            neg_res_q, neg_res_d;
   logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic            busy_q, busy_d, done_q, done_d;
   logic            start_ok, sgn_in, sgn_op, step_mul;
   logic [DW-1:0]   a_abs, b_abs, core_a;
   logic [2*DW-1:0] acc, prod;
`ifdef MDU_DIV_EN
   logic            neg_rem_q, neg_rem_d, div0_q, div0_d, step_div;
   logic [DW-1:0]   quo, rem;
`endif

   assign start_ok = (state_q == IDLE) && mdu.start && !mdu.flush;
   assign sgn_in   = is_signed_op(mdu.op);
   assign sgn_op   = is_signed_op(op_q);
   assign a_abs    = (sgn_in && mdu.opa[DW-1]) ? -mdu.opa : mdu.opa;
   assign b_abs    = (sgn_in && mdu.opb[DW-1]) ? -mdu.opb : mdu.opb;
   assign prod     = (sgn_op && neg_res_q) ? -acc : acc;
   assign step_mul = (state_q == MUL);
`ifdef MDU_DIV_EN
   assign step_div = (state_q == DIV);
   assign quo      = acc[DW-1:0];
   assign rem      = acc[2*DW-1:DW];
   // Divide by zero loads the raw dividend so FIX can hand it back as HI
   assign core_a   = (mdu.op[1] && (mdu.opb == '0)) ? mdu.opa : a_abs;
`else
   assign core_a   = a_abs;
`endif

   mdu_shift_core #(.DW(DW)) u_core (
      .CLK      (CLK),
      .RST      (RST),
      .load     (start_ok),
      .step_mul (step_mul),
`ifdef MDU_DIV_EN
      .step_div (step_div),
`endif
      .a_in     (core_a),
      .b_in     (b_abs),
      .acc      (acc)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_ok) begin
`ifdef MDU_DIV_EN
            if (!mdu.op[1])          state_d = MUL;
            else if (mdu.opb == '0)  state_d = FIX;
            else                     state_d = DIV;
`else
            state_d = mdu.op[1] ? FIX : MUL;
`endif
         end
         MUL: if (mdu.flush) state_d = IDLE;
              else if (count_q == CW'(DW - 1)) state_d = FIX;
`ifdef MDU_DIV_EN
         DIV: if (mdu.flush) state_d = IDLE;
              else if (count_q == CW'(DW - 1)) state_d = FIX;
`endif
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_d      = op_q;
      count_d   = count_q;
      neg_res_d = neg_res_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
`ifdef MDU_DIV_EN
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
`endif
      if (start_ok) begin
         op_d      = mdu.op;
         count_d   = '0;
         neg_res_d = sgn_in && (mdu.opa[DW-1] ^ mdu.opb[DW-1]);
`ifdef MDU_DIV_EN
         neg_rem_d = sgn_in && mdu.opa[DW-1];
         div0_d    = (mdu.opb == '0);
`endif
      end else if ((state_q == MUL) || (state_q == DIV)) begin
         count_d = count_q + CW'(1);
      end

      if ((state_q == FIX) && !mdu.flush) begin
         if (!op_q[1]) begin
            hi_d = prod[2*DW-1:DW];
            lo_d = prod[DW-1:0];
         end else begin
`ifdef MDU_DIV_EN
            if (div0_q) begin
               hi_d = quo;
               lo_d = '1;
            end else begin
               hi_d = (sgn_op && neg_rem_q) ? -rem : rem;
               lo_d = (sgn_op && neg_res_q) ? -quo : quo;
            end
`else
            hi_d = '0;
            lo_d = '0;
`endif
         end
      end

      // MTHI/MTLO land only while idle, which includes the done cycle
      if (state_q == IDLE) begin
         if (mdu.hi_we) hi_d = mdu.wdat;
         if (mdu.lo_we) lo_d = mdu.wdat;
      end

      busy_d = (state_d != IDLE);
      done_d = (state_q == FIX) && !mdu.flush;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         op_q      <= MD_MULT;
         count_q   <= '0;
         neg_res_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef MDU_DIV_EN
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
`endif
      end else begin
         op_q      <= op_d;
         count_q   <= count_d;
         neg_res_q <= neg_res_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef MDU_DIV_EN
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
`endif
      end
   end

   assign mdu.busy   = busy_q;
   assign mdu.done   = done_q;
   assign mdu.hi_out = hi_q;
   assign mdu.lo_out = lo_q;

endmodule

// File: tb/tb_stage_exe_mdu.sv
// Directed vector bench for stage_exe_mdu (DW = 32); divide expectations follow MDU_DIV_EN.
module tb_stage_exe_mdu;
   import cpu_types_pkg::*;

   localparam int DW = 32;
`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   stage_exe_mdu_if #(.DW(DW)) m ();
   stage_exe_mdu #(.DW(DW)) dut (.CLK(CLK), .RST(RST), .mdu(m));

   typedef struct {
      mdop_t       op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t        tbl [12];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] last_hi, last_lo, exp_hi, exp_lo;
   int          lat, bcnt, got, exp_lat, dones;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge where done is seen (or after a timeout)
   task automatic wait_done(output int lat_o, output int bcnt_o, output int got_o);
      lat_o = 0; bcnt_o = 0; got_o = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         m.start = 1'b0;
         if (m.done) begin
            got_o = 1;
            lat_o = i;
            break;
         end
         if (m.busy) bcnt_o++;
      end
   endtask

   task automatic run_op(input mdop_t o, input logic [31:0] a, input logic [31:0] b,
                         output int lat_o, output int bcnt_o, output int got_o);
      m.start = 1'b1; m.op = o; m.opa = a; m.opb = b;
      wait_done(lat_o, bcnt_o, got_o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      m.start = 1'b0; m.op = MD_MULT; m.opa = '0; m.opb = '0;
      m.flush = 1'b0; m.hi_we = 1'b0; m.lo_we = 1'b0; m.wdat = '0;

      tbl[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      tbl[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      tbl[2]  = '{MD_MULT,  32'h00000007, 32'h00000005, 32'h00000000, 32'h00000023};
      tbl[3]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      tbl[4]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      tbl[6]  = '{MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
      tbl[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      tbl[8]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      tbl[9]  = '{MD_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
      tbl[10] = '{MD_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
      tbl[11] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_hi", m.hi_out, 32'h0);
      check("rst_lo", m.lo_out, 32'h0);
      check("rst_busy", 32'(m.busy), 32'h0);
      check("rst_done", 32'(m.done), 32'h0);
      RST = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 12; i++) begin
         exp_hi = tbl[i].hi; exp_lo = tbl[i].lo; exp_lat = DW + 1;
         if (tbl[i].op == MD_DIV || tbl[i].op == MD_DIVU) begin
            if (!DIV_EN) begin
               exp_hi = '0; exp_lo = '0; exp_lat = 1;
            end else if (tbl[i].b == '0) begin
               exp_lat = 1;
            end
         end
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bcnt, got);
         $display("vec %0d op=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d busy=%0d",
                  i, tbl[i].op, tbl[i].a, tbl[i].b, m.hi_out, m.lo_out, lat, bcnt);
         check($sformatf("v%0d_done", i), 32'(got), 32'd1);
         check($sformatf("v%0d_hi", i), m.hi_out, exp_hi);
         check($sformatf("v%0d_lo", i), m.lo_out, exp_lo);
         check($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat));
         check($sformatf("v%0d_busycyc", i), 32'(bcnt), 32'(exp_lat));
         check($sformatf("v%0d_busy_in_done", i), 32'(m.busy), 32'h0);
         last_hi = exp_hi; last_lo = exp_lo;
      end

      // Flush mid-multiply: no done, HI/LO untouched
      m.start = 1'b1; m.op = MD_MULT; m.opa = 32'd5; m.opb = 32'd6;
      @(negedge CLK);
      m.start = 1'b0;
      repeat (9) @(negedge CLK);
      m.flush = 1'b1;
      @(negedge CLK);
      m.flush = 1'b0;
      check("flush_busy", 32'(m.busy), 32'h0);
      dones = 0;
      repeat (40) begin @(negedge CLK); if (m.done) dones++; end
      $display("seq flush: busy=%0d dones=%0d hi=%08h lo=%08h", m.busy, dones, m.hi_out, m.lo_out);
      check("flush_no_done", 32'(dones), 32'h0);
      check("flush_hi", m.hi_out, last_hi);
      check("flush_lo", m.lo_out, last_lo);

      // Start together with flush in IDLE: nothing starts
      m.start = 1'b1; m.flush = 1'b1; m.op = MD_MULTU; m.opa = 32'd9; m.opb = 32'd9;
      @(negedge CLK);
      m.start = 1'b0; m.flush = 1'b0;
      check("startflush_busy", 32'(m.busy), 32'h0);
      dones = 0;
      repeat (40) begin @(negedge CLK); if (m.done) dones++; end
      $display("seq start+flush: dones=%0d lo=%08h", dones, m.lo_out);
      check("startflush_no_done", 32'(dones), 32'h0);
      check("startflush_lo", m.lo_out, last_lo);

      // Back-to-back: second start issued in the done cycle of the first
      run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt, got);
      check("b2b_first_done", 32'(got), 32'd1);
      run_op(MD_MULT, 32'd3, 32'd4, lat, bcnt, got);
      $display("seq back-to-back: hi=%08h lo=%08h lat=%0d", m.hi_out, m.lo_out, lat);
      check("b2b_done", 32'(got), 32'd1);
      check("b2b_lat", 32'(lat), 32'(DW + 1));
      check("b2b_hi", m.hi_out, 32'h0);
      check("b2b_lo", m.lo_out, 32'h0000000C);

      // MTLO in the done cycle overwrites the fresh result
      m.lo_we = 1'b1; m.wdat = 32'h12345678;
      @(negedge CLK);
      m.lo_we = 1'b0;
      $display("seq mtlo in done cycle: hi=%08h lo=%08h", m.hi_out, m.lo_out);
      check("mtlo_done_lo", m.lo_out, 32'h12345678);
      check("mtlo_done_hi", m.hi_out, 32'h0);

      // MTLO while busy is ignored
      m.start = 1'b1; m.op = MD_MULTU; m.opa = 32'd2; m.opb = 32'd3;
      @(negedge CLK);
      m.start = 1'b0;
      repeat (4) @(negedge CLK);
      m.lo_we = 1'b1; m.wdat = 32'hDEADBEEF;
      @(negedge CLK);
      m.lo_we = 1'b0;
      check("mtlo_busy_lo_held", m.lo_out, 32'h12345678);
      wait_done(lat, bcnt, got);
      $display("seq mtlo while busy: lo=%08h", m.lo_out);
      check("mtlo_busy_done", 32'(got), 32'd1);
      check("mtlo_busy_lo", m.lo_out, 32'h00000006);

      // MTHI together with start: write lands, result later overwrites it
      m.hi_we = 1'b1; m.wdat = 32'hAAAA5555;
      m.start = 1'b1; m.op = MD_MULT; m.opa = 32'd2; m.opb = 32'hFFFFFFFD;
      @(negedge CLK);
      m.hi_we = 1'b0; m.start = 1'b0;
      check("mthi_start_hi_early", m.hi_out, 32'hAAAA5555);
      wait_done(lat, bcnt, got);
      $display("seq mthi+start: hi=%08h lo=%08h", m.hi_out, m.lo_out);
      check("mthi_start_done", 32'(got), 32'd1);
      check("mthi_start_hi", m.hi_out, 32'hFFFFFFFF);
      check("mthi_start_lo", m.lo_out, 32'hFFFFFFFA);

      // MTHI in IDLE, then asynchronous reset mid-operation
      m.hi_we = 1'b1; m.wdat = 32'h00000055;
      @(negedge CLK);
      m.hi_we = 1'b0;
      check("mthi_idle", m.hi_out, 32'h00000055);
      m.start = 1'b1; m.opa = 32'd100;
      m.op  = DIV_EN ? MD_DIVU : MD_MULTU;
      m.opb = DIV_EN ? 32'd7 : 32'd5;
      @(negedge CLK);
      m.start = 1'b0;
      repeat (4) @(negedge CLK);
      check("pre_rst_busy", 32'(m.busy), 32'h1);
      #2 RST = 1'b1;
      #1;
      $display("seq async reset: hi=%08h lo=%08h busy=%0d done=%0d", m.hi_out, m.lo_out, m.busy, m.done);
      check("arst_hi", m.hi_out, 32'h0);
      check("arst_lo", m.lo_out, 32'h0);
      check("arst_busy", 32'(m.busy), 32'h0);
      check("arst_done", 32'(m.done), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      check("post_rst_busy", 32'(m.busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stage_exe_mdu.md
# stage_exe_mdu

Iterative multiply/divide unit for the execute stage, parametrised in datapath width. It computes MULT/MULTU/DIV/DIVU into private HI/LO registers over multiple cycles and holds `busy` so the hazard unit can stall the pipeline. It also accepts MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. The unit sits beside the ALU in the execute stage and takes forwarded operands from the same mux outputs the ALU uses.

## Interface
- `DW`, 32: operand, HI and LO width. Must be ≥4 and even.
- `CLK` input 1: clock, rising edge.
- `RST` input 1: asynchronous reset, active-high.
- `start` input 1: request a new operation; sampled only in IDLE.
- `op` input 2: `mdop_t`. 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `opa` input DW: multiplicand or dividend (rs).
- `opb` input DW: multiplier or divisor (rt).
- `flush` input 1: abort the in-flight operation.
- `hi_we` / `lo_we` input 1 each: MTHI/MTLO write strobes.
- `wdat` input DW: MTHI/MTLO data.
- `busy` output 1: operation in flight; the pipeline stalls on it.
- `done` output 1: one-cycle pulse when HI/LO have just taken a result.
- `hi_out` / `lo_out` output DW: registered HI and LO.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset values: state = IDLE, `busy` = 0, `done` = 0, HI = 0, LO = 0, count = 0.
- Starting an operation, IDLE with `start` = 1 and `flush` = 0:
  - Latch `op`.
  - For signed ops, latch |opa| and |opb| and record the result sign and remainder sign.
  - MULT/MULTU → MUL. DIV/DIVU with nonzero `opb` → DIV.
  - DIV/DIVU with `opb` = 0 → FIX directly.
- MUL: one shift-add step per cycle over a 2·DW accumulator, DW steps. The final step goes to FIX.
- DIV: one restoring shift-subtract step per cycle, DW steps. The final step goes to FIX.
- FIX: apply sign correction, write HI/LO, pulse `done`, go to IDLE.
- Signed divide rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - MIN_INT / −1 gives LO = MIN_INT, HI = 0.
- Divide by zero: HI = opa, LO = all ones (signed and unsigned alike).
- Counter: log2(DW)+1 bits. It clears on start and moves to FIX when it reaches DW−1 after a step. It never wraps.
- `flush` in MUL, DIV or FIX: next state IDLE, no `done`, HI/LO unchanged.
- `flush` and `start` both high in IDLE: `flush` wins and nothing starts.
- `start` while `busy` = 1: ignored.
- `hi_we`/`lo_we` in IDLE, including the `done` cycle: the register takes `wdat` at the next edge. In the `done` cycle this overwrites the result just written.
- `hi_we`/`lo_we` while `busy` = 1: ignored. The hazard unit never issues them then.
- `hi_we` together with `start`: the write happens and the operation starts. The later result overwrites it.
- `RST` mid-operation: everything returns to the reset values immediately.

## Timing
- `start` is sampled at edge 0.
- Normal operation:
  - `busy` is high from after edge 0 through edge DW+1.
  - MUL or DIV steps occur at edges 1..DW.
  - FIX writes HI/LO at edge DW+1, with `done` = 1 in the following cycle. Total latency DW+1 cycles.
- Divide by zero: FIX at edge 1, `done` in the cycle after edge 1.
- `busy` is 0 during the `done` cycle, so back-to-back `start` is accepted there.
- `busy` and `done` are registered, never combinational from inputs.
- `hi_out`/`lo_out` are direct register outputs. MFHI issued in the `done` cycle sees the new value.

## Configuration
- `MDU_DIV_EN` defined: full divider as described.
- `MDU_DIV_EN` not defined:
  - No divider datapath and no DIV state.
  - DIV/DIVU go straight to FIX and write HI = 0, LO = 0, with `done` in the cycle after edge 1.
  - Multiply behaviour is unchanged.

## Structure
- `cpu_types_pkg` gains:
  - `mdop_t` (2-bit enum: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - `mdstate_t` (IDLE, MUL, DIV, FIX).
- `word_t` is reused when DW = 32.
- One sub-module, `mdu_shift_core`, holds the accumulator and remainder/quotient registers and the per-step shift-add and shift-subtract logic.
- The top level holds the FSM, counter, sign handling and HI/LO.

## Test plan
All cases use DW = 32 unless stated otherwise.
1. MULT opa = FFFFFFFD, opb = 00000007 → HI = FFFFFFFF, LO = FFFFFFEB. `done` exactly 33 cycles after `start`, `busy` high for 33 cycles.
2. MULTU FFFFFFFF × FFFFFFFF → HI = FFFFFFFE, LO = 00000001. A second `start` in the `done` cycle is accepted.
3. Signed divides:
   - DIV FFFFFFF9 / 00000002 → LO = FFFFFFFD, HI = FFFFFFFF.
   - DIV 80000000 / FFFFFFFF → LO = 80000000, HI = 0.
4. DIVU 00000064 / 0 → HI = 00000064, LO = FFFFFFFF, `done` in the cycle after edge 1. Build without `MDU_DIV_EN` → HI = LO = 0.
5. MULT started, then `flush` at cycle 10 → `busy` low next cycle, no `done`, HI/LO keep prior values. `start` with `flush` in IDLE → nothing starts.
6. MTLO 12345678 in the `done` cycle → LO = 12345678. `lo_we` while busy → ignored. `RST` mid-DIV → all outputs 0 asynchronously.
